// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   seq_state_t : sequencer state encoding (also visible as pll_reset_seq.state)
//   FAIL_CNT_W  : width of the saturating lock-failure debug counter
//   max5        : helper used to size the shared sequencer counter
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_VIDEO = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int FAIL_CNT_W = 4;

  function automatic int max5(input int a, input int b, input int c,
                              input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// sync_bit: single-bit synchronizer, STAGES flops deep, async active-low clear.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low clear (all stages go to 0)
//   d     in  asynchronous input bit
//   q     out synchronized bit, STAGES cycles of latency
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset sequencer sitting right after the core PLL.
// Holds the PLL in reset, waits for lock, requires lock to stay stable, then
// releases rst_video and, STAGE_GAP_CYC cycles later, rst_core. Loss of lock
// re-arms the sequence without resetting the PLL; a lock timeout retries the
// PLL. In RUN a soft reset request holds rst_core for a minimum time.
// Ports:
//   clk           in   sequencer clock (PLL output)
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock flag, asynchronous, synchronized here
//   sw_reset      in   soft core-reset request (level), synchronized here
//   pll_rst       out  PLL reset, active high
//   rst_video     out  video-domain reset, active high
//   rst_core      out  core reset, active high
//   ready         out  high in RUN when no soft hold is active
//   lock_fail_cnt out  saturating count of lock timeouts and lock losses
// The current FSM state is the internal signal 'state' (seq_state_t).
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC       = 1024,
  parameter int STAGE_GAP_CYC    = 64,
  parameter int SW_HOLD_CYC      = 256,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset,
  output logic                  pll_rst,
  output logic                  rst_video,
  output logic                  rst_core,
  output logic                  ready,
  output logic [FAIL_CNT_W-1:0] lock_fail_cnt
);

  localparam int MAX_CYC = max5(PLL_RST_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC,
                                STAGE_GAP_CYC, SW_HOLD_CYC);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  // Terminal counts: a state lasting N cycles exits on the cycle cnt == N-1.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SW_HOLD_CYC - 1);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             hold, next_hold;
  logic             cnt_clr;
  logic             fail_inc;
  logic             lk, sw;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_reset),
    .q     (sw)
  );

  // Next-state logic. Lock loss is tested first in every locked state so it
  // wins over sw and over any counter expiry in the same cycle.
  always_comb begin
    next_state = state;
    next_hold  = hold;
    cnt_clr    = 1'b0;
    fail_inc   = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == PLL_RST_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock on the timeout cycle still counts as a lock, not a failure.
        if (lk) begin
          next_state = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          next_state = PLL_RST;
          fail_inc   = 1'b1;
        end
      end
      STABLE: begin
        // A glitch here is not counted as a failure; stability just restarts.
        if (!lk) begin
          next_state = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          next_state = REL_VIDEO;
        end
      end
      REL_VIDEO: begin
        if (!lk) begin
          next_state = WAIT_LOCK;
          fail_inc   = 1'b1;
        end else if (cnt == GAP_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!lk) begin
          next_state = WAIT_LOCK;
          fail_inc   = 1'b1;
        end else if (sw) begin
          // Every sw cycle restarts the minimum-hold count.
          next_hold = 1'b1;
          cnt_clr   = 1'b1;
        end else if (hold && (cnt == HOLD_LAST)) begin
          next_hold = 1'b0;
        end
      end
      default: begin
        next_state = PLL_RST;
      end
    endcase
    if (next_state != state) cnt_clr = 1'b1;
    // The soft hold only exists inside RUN; it is never carried in or out.
    if (next_state != RUN) next_hold = 1'b0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PLL_RST;
      cnt           <= '0;
      hold          <= 1'b0;
      pll_rst       <= 1'b1;
      rst_video     <= 1'b1;
      rst_core      <= 1'b1;
      ready         <= 1'b0;
      lock_fail_cnt <= '0;
    end else begin
      state     <= next_state;
      hold      <= next_hold;
      cnt       <= cnt_clr ? '0 : cnt + CNT_W'(1);
      pll_rst   <= (next_state == PLL_RST);
      rst_video <= !((next_state == REL_VIDEO) || (next_state == RUN));
      rst_core  <= !((next_state == RUN) && !next_hold);
      ready     <= (next_state == RUN) && !next_hold;
      if (fail_inc && (lock_fail_cnt != '1)) begin
        lock_fail_cnt <= lock_fail_cnt + FAIL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with short timing parameters.
// Timing convention: inputs are driven 1 ns after a rising edge; "cycle k"
// is the interval following rising edge base+k, where base is the edge just
// before rst_n is released. Outputs are sampled on the falling edge. An
// output registered at edge k is therefore first seen in cycle k.
// Expected event cycles are pushed to exp_q when stimulus is driven and
// popped when the awaited output edge is observed.
module tb_pll_reset_seq;

  localparam int P_RST   = 4;
  localparam int P_TO    = 20;
  localparam int P_STB   = 8;
  localparam int P_GAP   = 5;
  localparam int P_HOLD  = 6;
  localparam int P_SYNC  = 2;
  localparam int RETRY   = P_RST + P_TO;          // PLL retry period
  // pll_locked driven in cycle d: synced lk=1 from cycle d+SYNC,
  // STABLE entered one edge later, lasts STABLE cycles.
  localparam int LOCK_TO_VIDEO = P_SYNC + 1 + P_STB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_reset;
  logic       pll_rst;
  logic       rst_video;
  logic       rst_core;
  logic       ready;
  logic [3:0] lock_fail_cnt;
  logic [7:0] obs;

  int          cyc = 0;
  int          base = 0;
  int          total = 0;
  int          bad = 0;
  int          pr_hi = 0;
  int          vid_hi = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp;

  pll_reset_seq #(
    .PLL_RST_CYC      (P_RST),
    .LOCK_TIMEOUT_CYC (P_TO),
    .STABLE_CYC       (P_STB),
    .STAGE_GAP_CYC    (P_GAP),
    .SW_HOLD_CYC      (P_HOLD),
    .SYNC_STAGES      (P_SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .sw_reset      (sw_reset),
    .pll_rst       (pll_rst),
    .rst_video     (rst_video),
    .rst_core      (rst_core),
    .ready         (ready),
    .lock_fail_cnt (lock_fail_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {pll_rst, rst_video, rst_core, ready, lock_fail_cnt};

  always @(negedge clk) begin
    if (pll_rst === 1'b1) pr_hi++;
    if (rst_video === 1'b1) vid_hi++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for an output to reach val; returns its cycle or all-ones.
  task automatic wait_out(input int sel, input logic val, input int limit,
                          output logic [31:0] at);
    logic cur;
    at = '1;
    for (int i = 0; i <= limit; i++) begin
      @(negedge clk);
      case (sel)
        0:       cur = pll_rst;
        1:       cur = rst_video;
        2:       cur = rst_core;
        default: cur = ready;
      endcase
      if (cur === val) begin
        at = 32'(cyc - base);
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 8'b1110_0000) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", obs, 8'b1110_0000);
    end
  endtask

  task automatic test_normal_start();
    do_reset();
    exp_q.push_back(32'(P_RST));
    wait_out(0, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL start_pll_rst_fall: got cycle %0d want %0d", got, exp);
    end
    to_cycle(10);
    pll_locked = 1'b1;
    exp_q.push_back(32'(10 + LOCK_TO_VIDEO));
    wait_out(1, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL start_video_release: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (rst_core !== 1'b1) begin
      bad++;
      $display("FAIL start_core_held: got %b want 1", rst_core);
    end
    exp_q.push_back(32'(10 + LOCK_TO_VIDEO + P_GAP));
    wait_out(2, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL start_core_release: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (obs !== 8'b0001_0000) begin
      bad++;
      $display("FAIL start_run_outputs: got %b want %b", obs, 8'b0001_0000);
    end
  endtask

  task automatic test_lock_glitch();
    do_reset();
    to_cycle(10);
    pll_locked = 1'b1;
    // STABLE entered at cycle 13; drive a one-cycle dip so synced lk is 0
    // exactly in cycle 18 (STABLE count 5). Lock returns in cycle 19, so
    // STABLE restarts at 20 and the video release lands at 28.
    to_cycle(16);
    pll_locked = 1'b0;
    to_cycle(17);
    pll_locked = 1'b1;
    exp_q.push_back(32'(17 + LOCK_TO_VIDEO));
    wait_out(1, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL glitch_video_release: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (lock_fail_cnt !== 4'd0) begin
      bad++;
      $display("FAIL glitch_fail_cnt: got %0d want 0", lock_fail_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int pr_snap;
    do_reset();
    to_cycle(10);
    pll_locked = 1'b1;
    exp_q.push_back(32'(10 + LOCK_TO_VIDEO + P_GAP));
    wait_out(2, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL loss_run_entry: got cycle %0d want %0d", got, exp);
    end
    pr_snap = pr_hi;
    to_cycle(30);
    pll_locked = 1'b0;
    exp_q.push_back(32'(30 + P_SYNC + 1));
    wait_out(3, 1'b0, 20, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL loss_ready_drop: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (obs !== 8'b0110_0001) begin
      bad++;
      $display("FAIL loss_outputs: got %b want %b", obs, 8'b0110_0001);
    end
    to_cycle(36);
    pll_locked = 1'b1;
    exp_q.push_back(32'(36 + LOCK_TO_VIDEO));
    wait_out(1, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL loss_relock_video: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (pr_hi !== pr_snap) begin
      bad++;
      $display("FAIL loss_pll_rst_quiet: got %0d high cycles want 0", pr_hi - pr_snap);
    end
    total++;
    if (lock_fail_cnt !== 4'd1) begin
      bad++;
      $display("FAIL loss_fail_cnt: got %0d want 1", lock_fail_cnt);
    end
  endtask

  // Continues from test_lock_loss: REL_VIDEO spans cycles 47..51.
  task automatic test_async_reset();
    to_cycle(49);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 8'b1110_0000) begin
      bad++;
      $display("FAIL async_reset_values: got %b want %b", obs, 8'b1110_0000);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
    // pll_locked is still high: synced lk is 1 from cycle 2, so WAIT_LOCK
    // (entered at 4) exits at once and STABLE starts at 5.
    exp_q.push_back(32'(P_RST));
    exp_q.push_back(32'(P_RST + 1 + P_STB));
    exp_q.push_back(32'(P_RST + 1 + P_STB + P_GAP));
    wait_out(0, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL replay_pll_rst_fall: got cycle %0d want %0d", got, exp);
    end
    wait_out(1, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL replay_video_release: got cycle %0d want %0d", got, exp);
    end
    wait_out(2, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL replay_core_release: got cycle %0d want %0d", got, exp);
    end
  endtask

  task automatic test_sw_hold();
    int vid_snap;
    do_reset();
    to_cycle(10);
    pll_locked = 1'b1;
    wait_out(2, 1'b0, 40, got);
    vid_snap = vid_hi;
    // sw_reset high in cycles 30..32 -> synced sw high in 32..34.
    to_cycle(30);
    sw_reset = 1'b1;
    exp_q.push_back(32'(30 + P_SYNC + 1));
    wait_out(2, 1'b1, 20, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sw_core_assert: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (obs !== 8'b0010_0000) begin
      bad++;
      $display("FAIL sw_hold_outputs: got %b want %b", obs, 8'b0010_0000);
    end
    to_cycle(33);
    sw_reset = 1'b0;
    // Last synced sw cycle 34; core held the following P_HOLD cycles.
    exp_q.push_back(32'(34 + P_HOLD + 1));
    wait_out(2, 1'b0, 30, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sw_core_release: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL sw_ready_back: got %b want 1", ready);
    end
    // Second hold extended by a one-cycle pulse: synced sw in 52..54, then 59.
    to_cycle(50);
    sw_reset = 1'b1;
    to_cycle(53);
    sw_reset = 1'b0;
    to_cycle(57);
    sw_reset = 1'b1;
    to_cycle(58);
    sw_reset = 1'b0;
    exp_q.push_back(32'(59 + P_HOLD + 1));
    wait_out(2, 1'b0, 40, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sw_hold_extend: got cycle %0d want %0d", got, exp);
    end
    total++;
    if (vid_hi !== vid_snap) begin
      bad++;
      $display("FAIL sw_video_untouched: got %0d high cycles want 0", vid_hi - vid_snap);
    end
    total++;
    if (obs !== 8'b0001_0000) begin
      bad++;
      $display("FAIL sw_end_outputs: got %b want %b", obs, 8'b0001_0000);
    end
  endtask

  task automatic test_lock_timeout();
    logic [3:0] want_cnt;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back(32'(RETRY * (k - 1) + P_RST));
      exp_q.push_back(32'(RETRY * k));
      wait_out(0, 1'b0, 60, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL timeout_pll_rst_fall_%0d: got cycle %0d want %0d", k, got, exp);
      end
      wait_out(0, 1'b1, 60, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL timeout_pll_rst_rise_%0d: got cycle %0d want %0d", k, got, exp);
      end
      want_cnt = (k > 15) ? 4'd15 : 4'(k);
      total++;
      if (obs !== {4'b1110, want_cnt}) begin
        bad++;
        $display("FAIL timeout_count_%0d: got %b want %b", k, obs, {4'b1110, want_cnt});
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_reset   = 1'b0;
    test_reset();
    test_normal_start();
    test_lock_glitch();
    test_lock_loss();
    test_async_reset();
    test_sw_hold();
    test_lock_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
